// File: rtl/membus_arbiter_pkg.sv
// Shared types and defaults for the instruction/data membus arbiter.
// Holds the response-routing tag carried through the in-order tag FIFO.
package membus_arbiter_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned ILEN                = 32;
  localparam int unsigned MEMBUS_DATA_WIDTH   = 64;
  localparam int unsigned ARB_MAX_OUTSTANDING = 2;
  localparam int unsigned ARB_STARVE_LIMIT    = 4;

  typedef struct packed {
    logic is_i;
    logic lane_hi;
  } arb_tag_t;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int unsigned width_for(int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/membus_arbiter_if.sv
// Simple valid/ready memory bus with in-order rvalid responses.
// Fetch ports instantiate it with DATA_WIDTH set to the instruction width.
interface membus_arbiter_if import membus_arbiter_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = XLEN,
  parameter int unsigned DATA_WIDTH = MEMBUS_DATA_WIDTH
);
  logic                      valid;
  logic                      ready;
  logic [ADDR_WIDTH-1:0]     addr;
  logic                      wen;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wmask;
  logic                      rvalid;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (
    output valid, addr, wen, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/membus_arbiter_tag_fifo.sv
// In-order FIFO of response-routing tags; one entry per issued request.
// The caller never pushes while full or pops while empty.
module membus_arbiter_tag_fifo import membus_arbiter_pkg::*; #(
  parameter int unsigned Depth = ARB_MAX_OUTSTANDING
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  arb_tag_t                     push_tag,
  input  logic                         pop,
  output arb_tag_t                     head,
  output logic [width_for(Depth)-1:0]  count,
  output logic                         full,
  output logic                         empty
);
  localparam int unsigned PtrW = width_for(Depth - 1);
  localparam int unsigned CntW = width_for(Depth);

  arb_tag_t            mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     count_q;

  function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/membus_arbiter.sv
// Arbitrates fetch and data masters onto one MMIO port with data priority,
// bounded fetch starvation, and in-order response routing via a tag FIFO.
module membus_arbiter import membus_arbiter_pkg::*; #(
  parameter int unsigned ADDR_WIDTH      = XLEN,
  parameter int unsigned DATA_WIDTH      = MEMBUS_DATA_WIDTH,
  parameter int unsigned IDATA_WIDTH     = ILEN,
  parameter int unsigned MAX_OUTSTANDING = ARB_MAX_OUTSTANDING,
  parameter int unsigned STARVE_LIMIT    = ARB_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,
  membus_arbiter_if.slave         i_membus,
  membus_arbiter_if.slave         d_membus,
  membus_arbiter_if.master        mmio_membus,
  output logic                    err_unexpected_rsp
);
  localparam int unsigned CntW = width_for(MAX_OUTSTANDING);
  localparam int unsigned StW  = width_for(STARVE_LIMIT);

  logic            sel_i;
  logic            full;
  logic            empty;
  logic            issue;
  logic            pop;
  arb_tag_t        push_tag;
  arb_tag_t        head;
  logic [CntW-1:0] tag_count;
  logic [StW-1:0]  starve_q;
  logic            err_q;
  logic            unused_fetch_wr;
  logic            unused_count;

  // Data wins unless fetch has been denied STARVE_LIMIT cycles in a row.
  assign sel_i = i_membus.valid & ~(d_membus.valid & (starve_q < StW'(STARVE_LIMIT)));

  assign mmio_membus.valid = (i_membus.valid | d_membus.valid) & ~full;
  assign i_membus.ready    = sel_i & mmio_membus.ready & ~full;
  assign d_membus.ready    = ~sel_i & d_membus.valid & mmio_membus.ready & ~full;

  always_comb begin
    mmio_membus.addr  = '0;
    mmio_membus.wen   = 1'b0;
    mmio_membus.wdata = '0;
    mmio_membus.wmask = '0;
    if (sel_i) begin
      mmio_membus.addr = i_membus.addr;
    end else if (d_membus.valid) begin
      mmio_membus.addr  = d_membus.addr;
      mmio_membus.wen   = d_membus.wen;
      mmio_membus.wdata = d_membus.wdata;
      mmio_membus.wmask = d_membus.wmask;
    end
  end

  assign issue    = mmio_membus.valid & mmio_membus.ready;
  assign push_tag = '{is_i: sel_i, lane_hi: sel_i & i_membus.addr[2]};
  assign pop      = mmio_membus.rvalid & ~empty;

  membus_arbiter_tag_fifo #(
    .Depth    (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (issue),
    .push_tag (push_tag),
    .pop      (pop),
    .head     (head),
    .count    (tag_count),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    i_membus.rvalid = pop & head.is_i;
    d_membus.rvalid = pop & ~head.is_i;
    i_membus.rdata  = '0;
    d_membus.rdata  = '0;
    if (i_membus.rvalid) begin
      i_membus.rdata = head.lane_hi ? mmio_membus.rdata[2*IDATA_WIDTH-1:IDATA_WIDTH]
                                    : mmio_membus.rdata[IDATA_WIDTH-1:0];
    end
    if (d_membus.rvalid) begin
      d_membus.rdata = mmio_membus.rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (mmio_membus.rvalid && empty) err_q <= 1'b1;
      if (!i_membus.valid || (sel_i && issue)) begin
        starve_q <= '0;
      end else if (starve_q < StW'(STARVE_LIMIT)) begin
        starve_q <= starve_q + StW'(1);
      end
    end
  end

  assign err_unexpected_rsp = err_q;

  // Fetch is read-only; its write fields exist only because the bus type is shared.
  assign unused_fetch_wr = ^{i_membus.wen, i_membus.wdata, i_membus.wmask};
  assign unused_count    = ^tag_count;

endmodule

// File: doc/membus_arbiter.md
# membus_arbiter

Two-master arbiter between the core's instruction-fetch bus and data bus, feeding the single 64-bit MMIO request port of `mmio_controller`. It grants one requester per cycle and tracks up to `MAX_OUTSTANDING` in-flight requests in an in-order tag FIFO. Each response is routed back to the master that issued it; fetch data is narrowed to the correct 32-bit lane. Data accesses have priority, and a bounded-starvation counter guarantees forward progress for fetch.

## Interface
- `ADDR_WIDTH`, default `XLEN`: address width of all buses.
- `DATA_WIDTH`, default `MEMBUS_DATA_WIDTH` (64): width of the data side and the downstream side.
- `IDATA_WIDTH`, default `ILEN` (32): fetch data width.
- `MAX_OUTSTANDING`, default 2: tag FIFO depth, ≥1.
- `STARVE_LIMIT`, default 4: number of consecutive denied fetch cycles that forces a fetch grant, ≥1.

- `clk`, input, 1: clock.
- `rst`, input, 1: **synchronous, active-high** reset.
- `i_membus`, slave modport, `i_membus` interface: fetch requests. Read-only; `rdata` is `IDATA_WIDTH` wide.
- `d_membus`, slave modport, `Membus` interface: data requests with `wen`, `wdata`, `wmask`.
- `mmio_membus`, master modport, `Membus` interface: the single downstream port.
- `err_unexpected_rsp`, output, 1: sticky flag. Set by an `mmio_membus.rvalid` that arrives while the tag FIFO is empty.

## Operation
- Downstream valid: `mmio_membus.valid = (d.valid | i.valid) & !full`.
  - `full` is defined as `count == MAX_OUTSTANDING`.
  - A response pop in the same cycle does not free a slot for that cycle's grant.
- Grant selection:
  - Data wins when `d.valid` is set and `starve_cnt < STARVE_LIMIT`.
  - Otherwise fetch wins if `i.valid`, else data.
- Master ready:
  - Granted master's `ready = mmio_membus.ready & !full`.
  - Non-granted master's `ready = 0`.
- Request muxing:
  - A data grant passes `addr/wen/wdata/wmask` through unchanged.
  - A fetch grant drives `wen=0`, `wdata='0`, `wmask='0`.
- Issue event: `mmio_membus.valid & mmio_membus.ready`.
  - On every issue, reads and writes alike, push tag `{is_i, lane_hi}`.
  - `lane_hi` is fetch `addr[2]`; it is 0 for data.
- Response contract: downstream returns exactly one `rvalid` per issued request, in order. Writes also return `rvalid`.
- Response routing, driven from the FIFO head while `rvalid` is set:
  - Head `is_i=1`: `i.rvalid=1`, `i.rdata = lane_hi ? rdata[63:32] : rdata[31:0]`.
  - Head `is_i=0`: `d.rvalid=1`, `d.rdata = rdata`.
  - The master that does not own the head sees `rvalid=0`.
  - Pop the head on the same cycle.
- FIFO empty with `rvalid=1`: both master `rvalid`s stay 0, the response is dropped, and `err_unexpected_rsp` is set.
- Starvation counter `starve_cnt` (saturating at `STARVE_LIMIT`):
  - Increments when `i.valid` is set and the fetch is not granted an issue.
  - Clears when a fetch issues, or when `i.valid=0`.

## Timing
- Request path is fully combinational: issue happens in the same cycle as master valid. No added latency.
- Response path is combinational from `mmio_membus.rvalid`/`rdata`: zero added latency.
- Simultaneous push and pop: `count` is unchanged, and head/tail pointers advance modulo `MAX_OUTSTANDING`.
- Reset values: `count=0`, pointers 0, `starve_cnt=0`, `err_unexpected_rsp=0`. All combinational outputs are 0 while idle.
- Reset mid-operation: all tags are discarded. Late responses that arrive after reset hit an empty FIFO and set `err_unexpected_rsp`. This is the intended diagnostic.
- Masters must hold valid and request fields stable until ready. The arbiter may switch its grant while a master waits, because nothing has been accepted yet.

## Structure
- Shared package `eei`:
  - `typedef struct packed {logic is_i; logic lane_hi;} arb_tag_t;`
  - Defaults `ARB_MAX_OUTSTANDING=2` and `ARB_STARVE_LIMIT=4`.
- Sub-module `membus_tag_fifo`:
  - Synchronous FIFO of `arb_tag_t`, depth `MAX_OUTSTANDING`.
  - Ports: push, pop, head, `count`, full, empty.
- This block replaces the inline I/D multiplexing in `core_top`.

## Test plan
- Fetch only:
  - Stimulus: `i.valid` with addr `0x1004`, downstream responds next cycle with `rdata=0xAAAA_BBBB_CCCC_DDDD`.
  - Required: `i.rvalid` with `rdata=0xAAAABBBB`. A second fetch at `0x1000` returns `0xCCCCDDDD`; `d.rvalid` stays 0.
- Simultaneous requests:
  - Stimulus: `i.valid` and `d.valid` (store, `wmask=0xFF`) in the same cycle.
  - Required: data is issued first with `wen=1`; fetch is issued the next cycle. Responses route D then I.
- Outstanding limit:
  - Stimulus: downstream `ready=1`, `rvalid` withheld, three data reads back-to-back.
  - Required: two issue; `d.ready=0` in the third cycle. After one `rvalid`, the third read issues one cycle later.
- Starvation, `STARVE_LIMIT=4`:
  - Stimulus: `d.valid` held high continuously and `i.valid` held high.
  - Required: fetch issues on the 5th cycle, then data resumes.
- Unexpected response:
  - Stimulus: `rvalid` pulsed with the FIFO empty.
  - Required: no master `rvalid`; `err_unexpected_rsp=1` until `rst`.
- Reset mid-flight:
  - Stimulus: issue two reads, assert `rst` for one cycle, then deliver two `rvalid`s.
  - Required: `count=0` after reset, neither master sees `rvalid`, and the error flag is set.
